// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and coordinate type, used by the sync
// generator and the downstream draw stage.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_clk_en.sv
// Pixel clock-enable divider: counts 0..CLK_DIV-1 and raises pix_en for the one
// clock in which the count sits at CLK_DIV-1.
module pixel_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;

  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
  end

  // pix_en is registered from div_next so it is high in exactly the div==last clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_next;
      pix_en <= (div_next == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel divider, row/line counters and registered decode.
// Define VGA_FRAME_TICK_EN to build the per-frame strobe; otherwise it is tied 0.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_In,
  output logic       Pixel_En_Out,
  output logic [9:0] Val_Row_Out,
  output logic [9:0] Val_Col_Out,
  output logic       Disp_Ena_Out,
  output logic       HSync_Out,
  output logic       VSync_Out,
  output logic       Frame_Tick_Out
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS      = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS      = coord_t'(V_VISIBLE);
  localparam coord_t V_VIS_LAST = coord_t'(V_VISIBLE - 1);
  localparam coord_t HS_FIRST   = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_LAST    = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST   = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_LAST    = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic   pix_en;
  coord_t row;
  coord_t col;
  coord_t row_next;
  coord_t col_next;
  logic   disp_ena;
  logic   hsync;
  logic   vsync;

  pixel_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clk_en (
    .clk    (Master_Clock_In),
    .rst    (Reset_In),
    .pix_en (pix_en)
  );

  always_comb begin
    row_next = row;
    col_next = col;
    if (pix_en) begin
      if (row == H_LAST) begin
        row_next = '0;
        col_next = (col == V_LAST) ? '0 : col + coord_t'(1);
      end else begin
        row_next = row + coord_t'(1);
      end
    end
  end

  // Decode from the next coordinates so the flags land in the same clock as the counters.
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      row      <= '0;
      col      <= '0;
      disp_ena <= 1'b0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else begin
      row      <= row_next;
      col      <= col_next;
      disp_ena <= (row_next < H_VIS) && (col_next < V_VIS);
      hsync    <= !in_range(row_next, HS_FIRST, HS_LAST);
      vsync    <= !in_range(col_next, VS_FIRST, VS_LAST);
    end
  end

`ifdef VGA_FRAME_TICK_EN
  logic frame_tick;

  // Fires with the advance from the last pixel of the last visible line to (0, V_VISIBLE).
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en && (row == H_LAST) && (col == V_VIS_LAST);
    end
  end

  assign Frame_Tick_Out = frame_tick;
`else
  assign Frame_Tick_Out = 1'b0;
`endif

  assign Pixel_En_Out = pix_en;
  assign Val_Row_Out  = row;
  assign Val_Col_Out  = col;
  assign Disp_Ena_Out = disp_ena;
  assign HSync_Out    = hsync;
  assign VSync_Out    = vsync;

endmodule
